mux_scan_checker: RTL
=====================

# mux_scan_checker

Sequential stage that sits directly upstream and downstream of the paired 4:1 multiplexers (gate-level `MUX` and switch-level `mux_buf`). It drives both multiplexers' shared select lines through channels 0..3 and waits a programmable settle interval per channel. It then samples both multiplexer outputs and reports the captured 4-bit words plus a per-channel mismatch mask. This replaces hand-timed delay stimulus with a clocked, repeatable equivalence check.

## Interface
- `SETTLE`, default 4: cycles the select is held stable before each capture; legal range 1..255.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous active-low reset, sampled on `clk` rising edge.
- `start`  input  1  request a scan; honoured only in IDLE.
- `abort`  input  1  cancel a scan in progress; synchronous.
- `y_a`  input  1  output of gate-level mux (`MUX`).
- `y_b`  input  1  output of switch-level mux (`mux_buf`).
- `sel`  output  2  select to both muxes; `sel[1]` drives S1, `sel[0]` drives S0.
- `busy`  output  1  high in SETTLE and CAPTURE.
- `valid`  output  1  one-cycle pulse: results updated.
- `sample_a`  output  4  bit k = `y_a` captured with `sel`=k.
- `sample_b`  output  4  bit k = `y_b` captured with `sel`=k.
- `mismatch`  output  4  `sample_a ^ sample_b`, registered with the samples.
- `err`  output  1  OR-reduction of `mismatch`, registered.

## Operation
- Reset (`rst_n`=0 at an edge): state IDLE, `sel`=0, internal counter=0, `busy`=0, `valid`=0, `sample_a`=0, `sample_b`=0, `mismatch`=0, `err`=0. Reset has priority over all inputs and takes effect mid-scan with no `valid`.
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE: if `start`=1 and `abort`=0, set `sel`=0 and counter=0, then go to SETTLE. Otherwise stay.
- SETTLE: counter increments each cycle. On the edge where counter==SETTLE-1, go to CAPTURE. The select is held for exactly SETTLE cycles.
- CAPTURE: one cycle. At its closing edge, `y_a` and `y_b` are written into bit `sel` of internal shadow registers.
  - If `sel`<3: `sel`++, counter=0, go to SETTLE.
  - If `sel`==3: copy shadows to `sample_a`/`sample_b`, compute `mismatch` and `err`, set `sel`=0, go to DONE.
- DONE: `valid`=1 for exactly this one cycle, then go to IDLE. `start` in DONE is ignored.
- `abort`=1 in SETTLE or CAPTURE: next state IDLE, `sel`=0, counter=0. Published outputs keep their previous values, and no `valid` is produced. `abort` in IDLE or DONE has no effect, and DONE still completes.
- `start` held high continuously produces back-to-back scans, each separated by one IDLE cycle.
- Published outputs change only on the edge entering DONE, so partial scans are never visible.

## Timing
- `start` is accepted at edge E0. Channel k is captured at edge E0+(k+1)(SETTLE+1).
- `valid` is high in the cycle following edge E0+4(SETTLE+1) and low after the next edge.
- Scan latency is 4(SETTLE+1)+1 cycles from acceptance to return to IDLE.
- With SETTLE=4, captures occur at E0+5, +10, +15, +20, and `valid` is high in cycle 21.
- `sel` changes only at capture edges or on accept/abort/reset, so it is glitch-free at clock granularity.
- All outputs are registered, with no combinational input-to-output path.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 cycles, then release. Require `sel`=0, `busy`=0, `valid`=0, `sample_a`=`sample_b`=`mismatch`=0, `err`=0, and no change for 10 cycles without `start`.
- Full scan, SETTLE=4, mux data a=1,b=0,c=1,d=1 on both muxes: pulse `start`. Require `sel` sequence 0,1,2,3 with 5 cycles each, `valid` in cycle 21, `sample_a`=`sample_b`=4'b1101, `mismatch`=0, `err`=0.
- Injected discrepancy: force `y_b`=0 while `sel`=2, same data. Require `sample_a`=4'b1101, `sample_b`=4'b1001, `mismatch`=4'b0100, `err`=1.
- Abort mid-scan: after a good scan (`sample_a`=4'b1101), start a new scan and assert `abort` when `sel`=1. Require IDLE on the next cycle, `sel`=0, `busy`=0, no `valid`, and `sample_a` still 4'b1101.
- Reset mid-scan: assert `rst_n`=0 during CAPTURE of channel 2. Require all outputs at reset values after that edge and no `valid`.
- Boundaries: with SETTLE=1, `start` held high for 30 cycles. Require captures every 2 cycles, `valid` 9 cycles after accept, and the next scan accepted 1 cycle after DONE. `start`+`abort` together in IDLE must leave the block in IDLE.

Source files
------------

// File: rtl/mux_scan_checker.sv
// rtl/mux_scan_checker.sv - clocked equivalence scan of two 4:1 muxes sharing select lines
// Steps sel through 0..3, settles, samples both mux outputs, publishes words and mismatch mask.
module mux_scan_checker #(
   parameter int unsigned SETTLE = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       y_a,
   input  logic       y_b,
   output logic [1:0] sel,
   output logic       busy,
   output logic       valid,
   output logic [3:0] sample_a,
   output logic [3:0] sample_b,
   output logic [3:0] mismatch,
   output logic       err
);

   localparam int CW = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_sel;
   logic [3:0]      r_shadow_a;
   logic [3:0]      r_shadow_b;
   logic [3:0]      w_cap_a;
   logic [3:0]      w_cap_b;
   logic            r_busy;
   logic            r_valid;
   logic [3:0]      r_sample_a;
   logic [3:0]      r_sample_b;
   logic [3:0]      r_mismatch;
   logic            r_err;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start && !abort) w_state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            if (abort)                          w_state_nxt = S_IDLE;
            else if (r_cnt == CW'(SETTLE - 1))  w_state_nxt = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (abort)               w_state_nxt = S_IDLE;
            else if (r_sel == 2'd3)  w_state_nxt = S_DONE;
            else                     w_state_nxt = S_SETTLE;
         end
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Shadow words with the current channel's bit replaced by the live mux outputs.
   always_comb begin
      w_cap_a        = r_shadow_a;
      w_cap_b        = r_shadow_b;
      w_cap_a[r_sel] = y_a;
      w_cap_b[r_sel] = y_b;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_sel      <= 2'd0;
         r_shadow_a <= 4'd0;
         r_shadow_b <= 4'd0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_sample_a <= 4'd0;
         r_sample_b <= 4'd0;
         r_mismatch <= 4'd0;
         r_err      <= 1'b0;
      end else begin
         r_busy  <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_CAPTURE);
         r_valid <= (w_state_nxt == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (start && !abort) begin
                  r_sel <= 2'd0;
                  r_cnt <= '0;
               end
            end
            S_SETTLE: begin
               if (abort) begin
                  r_sel <= 2'd0;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_CAPTURE: begin
               if (abort) begin
                  r_sel <= 2'd0;
                  r_cnt <= '0;
               end else begin
                  r_shadow_a <= w_cap_a;
                  r_shadow_b <= w_cap_b;
                  r_cnt      <= '0;
                  if (r_sel == 2'd3) begin
                     // Publish only on the final capture so partial scans stay hidden.
                     r_sample_a <= w_cap_a;
                     r_sample_b <= w_cap_b;
                     r_mismatch <= w_cap_a ^ w_cap_b;
                     r_err      <= |(w_cap_a ^ w_cap_b);
                     r_sel      <= 2'd0;
                  end else begin
                     r_sel <= r_sel + 2'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign sel      = r_sel;
   assign busy     = r_busy;
   assign valid    = r_valid;
   assign sample_a = r_sample_a;
   assign sample_b = r_sample_b;
   assign mismatch = r_mismatch;
   assign err      = r_err;

endmodule
